// File: rtl/video_in_stream_decoder.sv
// Camera timing (PIXEL_DATA/LINE_VALID/FRAME_VALID) to Avalon-ST packet stream with crop window,
// output FIFO, overflow/short-frame recovery. Optional VIDEO_IN_TEST_PATTERN_EN adds test_mode.
module video_in_stream_decoder #(
  parameter int DW         = 12,
  parameter int FIFO_DEPTH = 16,
  parameter int X_START    = 0,
  parameter int WIDTH      = 640,
  parameter int Y_START    = 0,
  parameter int HEIGHT     = 480
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          pixel_en,
  input  logic [DW-1:0] PIXEL_DATA,
  input  logic          LINE_VALID,
  input  logic          FRAME_VALID,
`ifdef VIDEO_IN_TEST_PATTERN_EN
  input  logic          test_mode,
`endif
  output logic [DW-1:0] out_data,
  output logic          out_startofpacket,
  output logic          out_endofpacket,
  output logic          out_valid,
  input  logic          out_ready,
  input  logic          clear_status,
  output logic          overflow,
  output logic          short_frame,
  output logic [15:0]   frame_count
);

  localparam int XEND = X_START + WIDTH;
  localparam int YEND = Y_START + HEIGHT;
  localparam int MAXV = (XEND > YEND) ? XEND : YEND;
  localparam int CW   = $clog2(MAXV + 1);
  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int BW   = DW + 2;

  localparam logic [CW-1:0] XS      = CW'(X_START);
  localparam logic [CW-1:0] YS      = CW'(Y_START);
  localparam logic [CW-1:0] W_C     = CW'(WIDTH);
  localparam logic [CW-1:0] H_C     = CW'(HEIGHT);
  localparam logic [CW-1:0] WL_C    = CW'(WIDTH - 1);
  localparam logic [CW-1:0] HL_C    = CW'(HEIGHT - 1);
  localparam logic [AW:0]   DEPTH_C = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {SYNC, ARMED, ACTIVE, FLUSH} state_t;

  state_t          state_q;
  logic            s_vld_q, s_lv_q, s_fv_q;
  logic [DW-1:0]   s_data_q;
  logic            p_lv_q, p_fv_q;
  logic [CW-1:0]   x_q, y_q;
  logic            sop_seen_q, eop_done_q, term_q;
  logic            overflow_q, short_q;
  logic [15:0]     fcnt_q;

  logic [BW-1:0]   mem_q [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q, rd_ptr_d;
  logic [AW:0]     count_q, count_d;
  logic [BW-1:0]   rd_data_q;
  logic            out_valid_q, out_valid_d;

  logic            rise, px_live, armed_rise;
  logic [CW-1:0]   cur_x, cur_y, off_x, off_y;
  logic            cap, cap_sop, cap_eop, cap_push, cap_drop;
  logic [DW-1:0]   cap_data;
  logic            pop, full, room, term_push, push;
  logic [BW-1:0]   push_word;
  logic            short_set, flush_end, term_owe;

  // Input sample register: everything downstream works on qualified samples only.
  always_ff @(posedge clk) begin
    if (reset) begin
      s_vld_q  <= 1'b0;
      s_lv_q   <= 1'b0;
      s_fv_q   <= 1'b0;
      s_data_q <= '0;
    end else begin
      s_vld_q <= pixel_en;
      if (pixel_en) begin
        s_lv_q   <= LINE_VALID;
        s_fv_q   <= FRAME_VALID;
        s_data_q <= PIXEL_DATA;
      end
    end
  end

  always_comb begin
    rise       = s_fv_q & ~p_fv_q;
    armed_rise = (state_q == ARMED) & rise;
    px_live    = s_vld_q & s_fv_q & s_lv_q & ((state_q == ACTIVE) | armed_rise);
    cur_x      = (state_q == ARMED) ? '0 : x_q;
    cur_y      = (state_q == ARMED) ? '0 : y_q;
    // Offsets wrap to large values below the window start, so one compare covers both bounds.
    off_x      = cur_x - XS;
    off_y      = cur_y - YS;
    cap        = px_live & (off_x < W_C) & (off_y < H_C) &
                 ~((state_q == ACTIVE) & eop_done_q);
    cap_sop    = (off_x == '0) & (off_y == '0);
    cap_eop    = (off_x == WL_C) & (off_y == HL_C);
`ifdef VIDEO_IN_TEST_PATTERN_EN
    cap_data   = test_mode ? (DW'(off_x) + DW'(off_y)) : s_data_q;
`else
    cap_data   = s_data_q;
`endif
    pop        = out_valid_q & out_ready;
    full       = (count_q == DEPTH_C);
    room       = ~full | pop;
    term_push  = term_q & room;
    cap_push   = cap & ~term_q & room;
    cap_drop   = cap & ~cap_push;
    push       = term_push | cap_push;
    push_word  = term_push ? {1'b0, 1'b1, {DW{1'b0}}} : {cap_sop, cap_eop, cap_data};
    short_set  = s_vld_q & ~s_fv_q & (state_q == ACTIVE) & sop_seen_q & ~eop_done_q;
    flush_end  = s_vld_q & ~s_fv_q & (state_q == FLUSH);
    term_owe   = short_set | flush_end;
    rd_ptr_d   = rd_ptr_q + AW'(pop);
    count_d    = count_q + (AW + 1)'(push) - (AW + 1)'(pop);
    out_valid_d = (count_q - (AW + 1)'(pop)) != '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= SYNC;
      p_lv_q     <= 1'b0;
      p_fv_q     <= 1'b0;
      x_q        <= '0;
      y_q        <= '0;
      sop_seen_q <= 1'b0;
      eop_done_q <= 1'b0;
      term_q     <= 1'b0;
      overflow_q <= 1'b0;
      short_q    <= 1'b0;
      fcnt_q     <= '0;
    end else begin
      if (s_vld_q) begin
        p_lv_q <= s_lv_q;
        p_fv_q <= s_fv_q;
      end
      case (state_q)
        SYNC: if (s_vld_q & ~s_fv_q) state_q <= ARMED;
        ARMED: begin
          if (s_vld_q & rise) begin
            state_q    <= ACTIVE;
            sop_seen_q <= 1'b0;
            eop_done_q <= 1'b0;
            y_q        <= '0;
            x_q        <= s_lv_q ? CW'(1) : '0;
          end
        end
        ACTIVE: begin
          if (s_vld_q) begin
            if (~s_fv_q) begin
              state_q <= ARMED;
            end else if (s_lv_q) begin
              x_q <= (x_q == '1) ? x_q : x_q + 1'b1;
            end else if (p_lv_q) begin
              y_q <= (y_q == '1) ? y_q : y_q + 1'b1;
              x_q <= '0;
            end
          end
        end
        FLUSH: if (s_vld_q & ~s_fv_q) state_q <= ARMED;
        default: state_q <= SYNC;
      endcase
      if (cap_drop) state_q <= FLUSH;
      if (cap_push & cap_sop) sop_seen_q <= 1'b1;
      if (cap_push & cap_eop) eop_done_q <= 1'b1;
      term_q     <= (term_q & ~term_push) | term_owe;
      overflow_q <= cap_drop  ? 1'b1 : (clear_status ? 1'b0 : overflow_q);
      short_q    <= short_set ? 1'b1 : (clear_status ? 1'b0 : short_q);
      if (push & push_word[DW]) fcnt_q <= fcnt_q + 16'd1;
    end
  end

  // Show-ahead FIFO with a registered read port; the head register is reloaded every cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      rd_data_q   <= '0;
      out_valid_q <= 1'b0;
    end else begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        if (push && (wr_ptr_q == AW'(i))) mem_q[i] <= push_word;
      end
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      rd_data_q   <= mem_q[rd_ptr_d];
      out_valid_q <= out_valid_d;
    end
  end

  assign out_data          = rd_data_q[DW-1:0];
  assign out_endofpacket   = rd_data_q[DW];
  assign out_startofpacket = rd_data_q[DW+1];
  assign out_valid         = out_valid_q;
  assign overflow          = overflow_q;
  assign short_frame       = short_q;
  assign frame_count       = fcnt_q;

endmodule
